// File: rtl/arith_sat_pkg.sv
// Shared saturation types and limit helpers for signed arithmetic blocks.
package arith_sat_pkg;

    localparam int STAGES = 2;

    typedef struct packed {
        logic pos;
        logic neg;
    } sat_flags_t;

    // Limits are returned as 32-bit patterns; callers keep the low w bits.
    function automatic logic [31:0] max_pos(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] min_neg(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/signed_sub_sat_core.sv
// Combinational raw a - b with signed overflow classification.
module signed_sub_sat_core
    import arith_sat_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] raw,
    output sat_flags_t       flags
);

    logic sa, sb, sr;

    assign raw = a - b;
    assign sa  = a[WIDTH-1];
    assign sb  = b[WIDTH-1];
    assign sr  = raw[WIDTH-1];

    // Overflow only possible when operand signs differ; the result sign then tells direction.
    assign flags.pos = ~sa &  sb &  sr;
    assign flags.neg =  sa & ~sb & ~sr;

endmodule

// File: rtl/signed_sub_sat_pipe.sv
// Two-stage saturating signed subtractor with valid/ready flow control and saturation counter.
module signed_sub_sat_pipe
    import arith_sat_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [WIDTH-1:0] diff,
    output logic             sat_pos,
    output logic             sat_neg,
    input  logic             clear_count,
    output logic [CNT_W-1:0] sat_count
);

    localparam logic [31:0]      MAX32   = max_pos(WIDTH);
    localparam logic [31:0]      MIN32   = min_neg(WIDTH);
    localparam logic [WIDTH-1:0] MAX_V   = MAX32[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MIN_V   = MIN32[WIDTH-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [STAGES:1]  vld_pipe;
    logic [WIDTH-1:0] raw_c, s1_raw;
    sat_flags_t       flags_c, s1_flags, s2_flags;
    logic             ld1, ld2, up_fire, dn_fire;

    signed_sub_sat_core #(.WIDTH(WIDTH)) u_core (
        .a     (a),
        .b     (b),
        .raw   (raw_c),
        .flags (flags_c)
    );

    // A stage loads when empty or when its successor is draining it this cycle.
    assign ld2      = ~vld_pipe[2] | down_ready;
    assign ld1      = ~vld_pipe[1] | ld2;
    assign up_ready = ld1;
    assign up_fire  = up_valid & ld1;
    assign dn_fire  = vld_pipe[2] & down_ready;

    assign down_valid = vld_pipe[2];
    assign sat_pos    = s2_flags.pos;
    assign sat_neg    = s2_flags.neg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_raw   <= '0;
            s1_flags <= '0;
            s2_flags <= '0;
            diff     <= '0;
        end else begin
            if (ld1) begin
                vld_pipe[1] <= up_valid;
                if (up_fire) begin
                    s1_raw   <= raw_c;
                    s1_flags <= flags_c;
                end
            end
            if (ld2) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    s2_flags <= s1_flags;
                    diff     <= s1_flags.pos ? MAX_V :
                                s1_flags.neg ? MIN_V : s1_raw;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (clear_count) begin
            sat_count <= '0;
        end else if (dn_fire && (s2_flags.pos || s2_flags.neg) && sat_count != CNT_MAX) begin
            sat_count <= sat_count + CNT_ONE;
        end
    end

endmodule

// File: doc/signed_sub_sat_pipe.md
SIGNED_SUB_SAT_PIPE -- requirements
Module: signed_sub_sat_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width in bits (two's complement), legal range 2..32.
REQ-002 SHALL have parameter CNT_W, default 8, width of the saturation event counter.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port up_valid  input  1  operand pair a, b valid.
REQ-006 SHALL have port up_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  WIDTH  signed minuend.
REQ-008 SHALL have port b  input  WIDTH  signed subtrahend.
REQ-009 SHALL have port down_valid  output  1  diff and flags valid.
REQ-010 SHALL have port down_ready  input  1  consumer accepts result.
REQ-011 SHALL have port diff  output  WIDTH  saturated signed a - b.
REQ-012 SHALL have port sat_pos  output  1  diff was clamped to the maximum positive value.
REQ-013 SHALL have port sat_neg  output  1  diff was clamped to the minimum negative value.
REQ-014 SHALL have port clear_count  input  1  synchronous clear of sat_count.
REQ-015 SHALL have port sat_count  output  CNT_W  number of delivered saturated results.

Function
REQ-016 SHALL compute the raw difference a - b modulo 2^WIDTH.
REQ-017 SHALL detect positive overflow as: a non-negative, b negative, raw result MSB set -> diff = 0 followed by all ones (e.g. 0111), sat_pos = 1.
REQ-018 SHALL detect negative overflow as: a negative, b non-negative, raw result MSB clear -> diff = 1 followed by all zeros (e.g. 1000), sat_neg = 1.
REQ-019 SHALL otherwise output the raw difference with sat_pos = sat_neg = 0; sat_pos and sat_neg SHALL never both be 1.
REQ-020 SHALL treat b = minimum negative value with no special case: the REQ-017/018 rules alone decide the result (0 - (-8) -> 7 saturated; -1 - (-8) -> 7 not saturated).
REQ-021 SHALL be a 2-stage pipeline: stage 1 registers the raw difference and overflow flags; stage 2 registers diff, sat_pos, sat_neg.
REQ-022 SHALL have a latency of exactly 2 cycles from the up handshake (up_valid & up_ready) to down_valid when down_ready stays high.
REQ-023 SHALL sustain a throughput of 1 result per cycle when down_ready stays high.
REQ-024 SHALL give each stage a valid bit, and a stage SHALL load when it is empty or its successor advances; up_ready = stage-1 empty or stage 1 advancing.
REQ-025 SHALL hold down_valid, diff, sat_pos and sat_neg stable while down_valid = 1 and down_ready = 0.
REQ-026 SHALL not lose, duplicate or reorder results under any down_ready pattern.
REQ-027 SHALL increment sat_count by 1 on each down handshake with sat_pos or sat_neg set, and SHALL stop at 2^CNT_W - 1 with no wrap-around.
REQ-028 SHALL set sat_count to 0 on clear_count = 1, taking priority over a simultaneous increment.

Reset
REQ-029 SHALL, while rst_n = 0, immediately force both stage valid bits, down_valid, sat_pos, sat_neg, diff and sat_count to 0, independent of clk.
REQ-030 SHALL drop in-flight operands when reset is asserted mid-operation; the first result after rst_n deasserts SHALL come from the first post-reset up handshake.
REQ-031 SHALL drive up_ready = 1 in the first cycle after reset deassertion.

Structure
REQ-032 SHALL place sat_flags_t (2-bit packed struct: pos, neg) and functions max_pos(WIDTH)/min_neg(WIDTH) in a shared package, arith_sat_pkg.
REQ-033 SHALL put the combinational raw difference and overflow detection in one sub-module, signed_sub_sat_core, instantiated in stage 1.

Verification (WIDTH = 4)
REQ-034 SHALL test directed vectors with down_ready = 1: 3-(-6)->7 pos; -3-6->-8 neg; -8-(-8)->0; 0-(-8)->7 pos; -1-(-8)->7 none; 2-5->-3 none; each result appearing exactly 2 cycles after acceptance.
REQ-035 SHALL test backpressure: issue 4 back-to-back operand pairs, hold down_ready = 0 for 5 cycles -> up_ready falls after 2 accepts, outputs stay stable, and all 4 results emerge in order once down_ready = 1.
REQ-036 SHALL test counter saturation with CNT_W = 2: deliver 5 saturated results -> sat_count reads 1, 2, 3, 3, 3.
REQ-037 SHALL test simultaneous clear: clear_count = 1 in the same cycle as a saturated down handshake -> sat_count = 0 in the next cycle.
REQ-038 SHALL test reset mid-operation: assert rst_n = 0 with both stages full -> down_valid = 0 and sat_count = 0 immediately; after release, one op 1-1 -> diff = 0 after 2 cycles with no stale output.
REQ-039 SHALL run a randomized check against the signed reference clamp(a - b, -8, 7) over all 256 operand pairs with random down_ready.
